min_max_ctrl: RTL and testbench

Sequential control stage directly upstream of the min/max LED bar display. It turns raw user inputs into the stable, registered operand set the display consumes: command, bounds, a button-stepped current value with auto-repeat, and the blink signal driving the display's oscillating LEDs. All outputs are registered, so the display sees glitch-free values that change only on clock edges.

---
 rtl/min_max_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_min_max_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/min_max_ctrl.sv
// min_max_ctrl: registered operand stage feeding the min/max LED bar display.
// Ports:
//   clk_i, rst_i      clock and synchronous active-high reset
//   up_i, down_i      raw asynchronous buttons (active-high)
//   com_i/min_i/max_i requested command and bounds, registered onto
//                     com_o/min_o/max_o one cycle later
//   value_o           button-stepped value with auto-repeat and saturation
//   osc_o             50 % duty blink signal for oscillating LEDs
module min_max_ctrl #(
   parameter int VALSIZE      = 4,
   parameter int OSC_HALF     = 5_000_000,
   parameter int REPEAT_DELAY = 25_000_000,
   parameter int REPEAT_RATE  = 5_000_000
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               up_i,
   input  logic               down_i,
   input  logic [1:0]         com_i,
   input  logic [VALSIZE-1:0] min_i,
   input  logic [VALSIZE-1:0] max_i,
   output logic [1:0]         com_o,
   output logic [VALSIZE-1:0] min_o,
   output logic [VALSIZE-1:0] max_o,
   output logic [VALSIZE-1:0] value_o,
   output logic               osc_o
);

   localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                         REPEAT_DELAY : REPEAT_RATE;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam int OW   = (OSC_HALF > 1) ? $clog2(OSC_HALF) : 1;

   localparam logic [CW-1:0] DELAY_END = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] RATE_END  = CW'(REPEAT_RATE - 1);
   localparam logic [OW-1:0] OSC_END   = OW'(OSC_HALF - 1);

   localparam logic [VALSIZE-1:0] VAL_MAX = '1;
   localparam logic [VALSIZE-1:0] VAL_MIN = '0;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT,
      LOCK
   } state_t;

   // ---------------------------------------------------------------
   // Registered pass-through of command and bounds
   // ---------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         com_o <= 2'b10;
         min_o <= '0;
         max_o <= '1;
      end else begin
         com_o <= com_i;
         min_o <= min_i;
         max_o <= max_i;
      end
   end

   // ---------------------------------------------------------------
   // Two-flop synchronizers for the raw buttons
   // ---------------------------------------------------------------
   logic up_s1;
   logic up_s2;
   logic down_s1;
   logic down_s2;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         up_s1   <= 1'b0;
         up_s2   <= 1'b0;
         down_s1 <= 1'b0;
         down_s2 <= 1'b0;
      end else begin
         up_s1   <= up_i;
         up_s2   <= up_s1;
         down_s1 <= down_i;
         down_s2 <= down_s1;
      end
   end

   // ---------------------------------------------------------------
   // Step / auto-repeat FSM
   // ---------------------------------------------------------------
   state_t        state;
   state_t        state_nx;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;
   logic          dir_up;
   logic          dir_nx;
   logic          step;

   logic both;
   logic none;
   logic held;

   assign both = up_s2 & down_s2;
   assign none = ~up_s2 & ~down_s2;
   // With exactly one button pressed, held drops when the pressed
   // button is not the one that started this press (direct switch).
   assign held = dir_up ? up_s2 : down_s2;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= IDLE;
         cnt    <= '0;
         dir_up <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         dir_up <= dir_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      dir_nx   = dir_up;
      step     = 1'b0;
      unique case (state)
         IDLE: begin
            if (both) begin
               state_nx = LOCK;
               cnt_nx   = '0;
            end else if (!none) begin
               step     = 1'b1;
               dir_nx   = up_s2;
               cnt_nx   = '0;
               state_nx = DELAY;
            end
         end
         DELAY: begin
            if (both) begin
               state_nx = LOCK;
               cnt_nx   = '0;
            end else if (none || !held) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (cnt == DELAY_END) begin
               step     = 1'b1;
               cnt_nx   = '0;
               state_nx = REPEAT;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         REPEAT: begin
            if (both) begin
               state_nx = LOCK;
               cnt_nx   = '0;
            end else if (none || !held) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (cnt == RATE_END) begin
               step   = 1'b1;
               cnt_nx = '0;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         LOCK: begin
            if (none) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Saturating value register
   // ---------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         value_o <= '0;
      end else if (step) begin
         if (dir_nx) begin
            if (value_o != VAL_MAX) begin
               value_o <= value_o + VALSIZE'(1);
            end
         end else begin
            if (value_o != VAL_MIN) begin
               value_o <= value_o - VALSIZE'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------
   // Free-running blink oscillator
   // ---------------------------------------------------------------
   logic [OW-1:0] ocnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ocnt  <= '0;
         osc_o <= 1'b0;
      end else if (ocnt == OSC_END) begin
         ocnt  <= '0;
         osc_o <= ~osc_o;
      end else begin
         ocnt <= ocnt + OW'(1);
      end
   end

endmodule

// File: tb/tb_min_max_ctrl.sv
// Directed self-checking bench for min_max_ctrl.
// Uses OSC_HALF=4, REPEAT_DELAY=8, REPEAT_RATE=3.
module tb_min_max_ctrl;

   logic       clk;
   logic       rst_i;
   logic       up_i;
   logic       down_i;
   logic [1:0] com_i;
   logic [3:0] min_i;
   logic [3:0] max_i;
   logic [1:0] com_o;
   logic [3:0] min_o;
   logic [3:0] max_o;
   logic [3:0] value_o;
   logic       osc_o;

   int vectors;
   int miscompares;

   min_max_ctrl #(
      .VALSIZE(4),
      .OSC_HALF(4),
      .REPEAT_DELAY(8),
      .REPEAT_RATE(3)
   ) dut (
      .clk_i(clk),
      .rst_i(rst_i),
      .up_i(up_i),
      .down_i(down_i),
      .com_i(com_i),
      .min_i(min_i),
      .max_i(max_i),
      .com_o(com_o),
      .min_o(min_o),
      .max_o(max_o),
      .value_o(value_o),
      .osc_o(osc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      up_i   = 1'b0;
      down_i = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   // Steps seen by tick t of a continuous hold: first at tick 3,
   // then +8, then every 3.
   function automatic int sched(input int t);
      int c;
      c = 0;
      if (t >= 3) c++;
      if (t >= 11) c += 1 + (t - 11) / 3;
      return c;
   endfunction

   task automatic test_reset();
      rst_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         com_i  = 2'($urandom);
         min_i  = 4'($urandom);
         max_i  = 4'($urandom);
         up_i   = 1'($urandom);
         down_i = 1'($urandom);
         tick();
      end
      vectors++;
      if (com_o !== 2'b10) begin
         miscompares++;
         $display("FAIL reset_com: got %b expected 10", com_o);
      end
      vectors++;
      if (min_o !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_min: got %0d expected 0", min_o);
      end
      vectors++;
      if (max_o !== 4'd15) begin
         miscompares++;
         $display("FAIL reset_max: got %0d expected 15", max_o);
      end
      vectors++;
      if (value_o !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_value: got %0d expected 0", value_o);
      end
      vectors++;
      if (osc_o !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_osc: got %b expected 0", osc_o);
      end
      rst_i  = 1'b0;
      up_i   = 1'b0;
      down_i = 1'b0;
      com_i  = 2'b10;
      min_i  = 4'd0;
      max_i  = 4'd15;
      for (int n = 1; n <= 16; n++) begin
         logic exp_osc;
         tick();
         exp_osc = ((n / 4) % 2) == 1;
         vectors++;
         if (osc_o !== exp_osc) begin
            miscompares++;
            $display("FAIL osc_edge%0d: got %b expected %b",
                     n, osc_o, exp_osc);
         end
      end
   endtask

   task automatic test_single_tap();
      int exp_v;
      for (int t = 1; t <= 8; t++) begin
         up_i = (t <= 2);
         tick();
         exp_v = (t >= 3) ? 1 : 0;
         vectors++;
         if (value_o !== 4'(exp_v)) begin
            miscompares++;
            $display("FAIL tap_up t%0d: got %0d expected %0d",
                     t, value_o, exp_v);
         end
      end
      for (int t = 1; t <= 8; t++) begin
         down_i = (t <= 2);
         tick();
         exp_v = (t >= 3) ? 0 : 1;
         vectors++;
         if (value_o !== 4'(exp_v)) begin
            miscompares++;
            $display("FAIL tap_down t%0d: got %0d expected %0d",
                     t, value_o, exp_v);
         end
      end
      idle(4);
   endtask

   task automatic test_auto_repeat();
      int exp_v;
      for (int t = 1; t <= 28; t++) begin
         up_i = (t <= 20);
         tick();
         exp_v = sched((t <= 20) ? t : 20);
         vectors++;
         if (value_o !== 4'(exp_v)) begin
            miscompares++;
            $display("FAIL repeat t%0d: got %0d expected %0d",
                     t, value_o, exp_v);
         end
      end
      idle(4);
   endtask

   task automatic test_saturation();
      int exp_v;
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      up_i  = 1'b1;
      for (int t = 1; t <= 45; t++) tick();
      idle(6);
      vectors++;
      if (value_o !== 4'd14) begin
         miscompares++;
         $display("FAIL sat_pre14: got %0d expected 14", value_o);
      end
      up_i = 1'b1;
      for (int t = 1; t <= 30; t++) begin
         tick();
         exp_v = (t < 3) ? 14 : 15;
         vectors++;
         if (value_o !== 4'(exp_v)) begin
            miscompares++;
            $display("FAIL sat_up t%0d: got %0d expected %0d",
                     t, value_o, exp_v);
         end
      end
      idle(6);
      down_i = 1'b1;
      for (int t = 1; t <= 45; t++) tick();
      idle(6);
      vectors++;
      if (value_o !== 4'd1) begin
         miscompares++;
         $display("FAIL sat_pre1: got %0d expected 1", value_o);
      end
      down_i = 1'b1;
      for (int t = 1; t <= 30; t++) begin
         tick();
         exp_v = (t < 3) ? 1 : 0;
         vectors++;
         if (value_o !== 4'(exp_v)) begin
            miscompares++;
            $display("FAIL sat_down t%0d: got %0d expected %0d",
                     t, value_o, exp_v);
         end
      end
      idle(6);
   endtask

   task automatic test_lock();
      int exp_v;
      for (int k = 0; k < 2; k++) begin
         up_i = 1'b1;
         tick();
         tick();
         idle(6);
      end
      vectors++;
      if (value_o !== 4'd2) begin
         miscompares++;
         $display("FAIL lock_pre: got %0d expected 2", value_o);
      end
      for (int t = 1; t <= 35; t++) begin
         up_i   = (t <= 10);
         down_i = (t <= 20) || (t == 26) || (t == 27);
         tick();
         exp_v = (t >= 28) ? 1 : 2;
         vectors++;
         if (value_o !== 4'(exp_v)) begin
            miscompares++;
            $display("FAIL lock t%0d: got %0d expected %0d",
                     t, value_o, exp_v);
         end
      end
      idle(4);
   endtask

   task automatic test_switch();
      int exp_v;
      for (int t = 1; t <= 32; t++) begin
         up_i   = (t <= 12);
         down_i = (t >= 13) && (t <= 23);
         tick();
         if (t < 3)       exp_v = 1;
         else if (t < 11) exp_v = 2;
         else if (t < 14) exp_v = 3;
         else if (t < 16) exp_v = 4;
         else if (t < 24) exp_v = 3;
         else             exp_v = 2;
         vectors++;
         if (value_o !== 4'(exp_v)) begin
            miscompares++;
            $display("FAIL switch t%0d: got %0d expected %0d",
                     t, value_o, exp_v);
         end
      end
      idle(4);
   endtask

   task automatic test_pass_through();
      logic [1:0] pc [3];
      logic [3:0] pn [3];
      logic [3:0] px [3];
      logic [1:0] prev_c;
      pc = '{2'b00, 2'b01, 2'b11};
      pn = '{4'd3, 4'd9, 4'd15};
      px = '{4'd12, 4'd4, 4'd0};
      for (int i = 0; i < 3; i++) begin
         prev_c = com_o;
         com_i = pc[i];
         min_i = pn[i];
         max_i = px[i];
         #1;
         vectors++;
         if (com_o !== prev_c) begin
            miscompares++;
            $display("FAIL pass_early%0d: got %b expected %b",
                     i, com_o, prev_c);
         end
         tick();
         vectors++;
         if ({com_o, min_o, max_o} !== {pc[i], pn[i], px[i]}) begin
            miscompares++;
            $display("FAIL pass%0d: got %b/%0d/%0d expected %b/%0d/%0d",
                     i, com_o, min_o, max_o, pc[i], pn[i], px[i]);
         end
      end
   endtask

   task automatic test_reset_mid_hold();
      int exp_v;
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      up_i  = 1'b1;
      for (int t = 1; t <= 26; t++) begin
         tick();
         exp_v = sched(t);
         vectors++;
         if (value_o !== 4'(exp_v)) begin
            miscompares++;
            $display("FAIL hold t%0d: got %0d expected %0d",
                     t, value_o, exp_v);
         end
      end
      rst_i = 1'b1;
      tick();
      vectors++;
      if ({com_o, min_o, max_o, value_o, osc_o} !==
          {2'b10, 4'd0, 4'd15, 4'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL midrst: got %b/%0d/%0d/%0d/%b expected 10/0/15/0/0",
                  com_o, min_o, max_o, value_o, osc_o);
      end
      rst_i = 1'b0;
      for (int t = 1; t <= 3; t++) begin
         tick();
         exp_v = (t == 3) ? 1 : 0;
         vectors++;
         if (value_o !== 4'(exp_v)) begin
            miscompares++;
            $display("FAIL post_rst t%0d: got %0d expected %0d",
                     t, value_o, exp_v);
         end
      end
      idle(6);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_i       = 1'b1;
      up_i        = 1'b0;
      down_i      = 1'b0;
      com_i       = 2'b00;
      min_i       = 4'd0;
      max_i       = 4'd0;
      tick();
      test_reset();
      test_single_tap();
      test_auto_repeat();
      test_saturation();
      test_lock();
      test_switch();
      test_pass_through();
      test_reset_mid_hold();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
